// File: rtl/regfile_sb.sv
// rtl/regfile_sb.sv - register file with EX/MEM/WB bypass and long-latency scoreboard
module regfile_sb #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRP = 2,
    parameter int CW  = AW + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRP-1:0]    ren,
    input  logic [NRP*AW-1:0] raddr,
    output logic [NRP*DW-1:0] rdata,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DW-1:0]     wdata,
    input  logic              ex_wen,
    input  logic [AW-1:0]     ex_waddr,
    input  logic [DW-1:0]     ex_wdata,
    input  logic              ex_nofwd,
    input  logic              mem_wen,
    input  logic [AW-1:0]     mem_waddr,
    input  logic [DW-1:0]     mem_wdata,
    input  logic              mem_nofwd,
    input  logic              iss_valid,
    input  logic [AW-1:0]     iss_addr,
    input  logic              cmp_valid,
    input  logic [AW-1:0]     cmp_addr,
    output logic              stallreq,
    output logic [CW-1:0]     busy_cnt
);

    localparam int DEPTH = 1 << AW;

    logic [DW-1:0]    mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] set_vec;
    logic [DEPTH-1:0] clr_vec;
    logic [DEPTH-1:0] busy_next;
    logic             busy_rise;
    logic             busy_fall;
    logic [NRP-1:0]   port_stall;

    // Storage array; entry 0 is never written so it always reads back zero
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            mem[waddr] <= wdata;
        end
    end

    // Next busy vector: a same-edge issue overrides a completion to the same entry
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (iss_valid && (iss_addr != '0)) begin
            set_vec[iss_addr] = 1'b1;
        end
        if (cmp_valid) begin
            clr_vec[cmp_addr] = 1'b1;
        end
        busy_next    = (busy & ~clr_vec) | set_vec;
        busy_next[0] = 1'b0;
        busy_rise    = |(busy_next & ~busy);
        busy_fall    = |(busy & ~busy_next);
    end

    // Busy bits and a running count of them, kept in step edge by edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy     <= '0;
            busy_cnt <= '0;
        end else begin
            busy <= busy_next;
            if (busy_rise && !busy_fall) begin
                busy_cnt <= busy_cnt + CW'(1);
            end else if (busy_fall && !busy_rise) begin
                busy_cnt <= busy_cnt - CW'(1);
            end
        end
    end

    genvar g;
    for (g = 0; g < NRP; g++) begin : g_port
        logic [AW-1:0] ra;
        logic          rv;
        logic          ex_hit;
        logic          mem_hit;
        logic          wb_hit;
        logic          fwd_stall;
        logic          sb_stall;
        logic          supplied;

        assign ra      = raddr[g*AW +: AW];
        assign rv      = ren[g] && (ra != '0);
        assign ex_hit  = ex_wen && (ex_waddr == ra);
        assign mem_hit = mem_wen && (mem_waddr == ra);
        assign wb_hit  = we && (waddr == ra);

        // Youngest producer wins: EX, then MEM, then WB, then the array
        assign rdata[g*DW +: DW] = (ra == '0) ? '0        :
                                   ex_hit     ? ex_wdata  :
                                   mem_hit    ? mem_wdata :
                                   wb_hit     ? wdata     : mem[ra];

        // A bypass source with valid data covers a busy entry for this cycle
        assign supplied   = (ex_hit && !ex_nofwd) || (mem_hit && !mem_nofwd) || wb_hit;
        assign fwd_stall  = (ex_hit && ex_nofwd) || (!ex_hit && mem_hit && mem_nofwd);
        assign sb_stall   = busy[ra] && !supplied;
        assign port_stall[g] = rv && (fwd_stall || sb_stall);
    end

    assign stallreq = |port_stall;

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DW, default 32, data width of each register.
REQ-002 Parameter AW, default 5, address width; depth = 2**AW entries.
REQ-003 Parameter NRP, default 2, number of read ports (1..4).
REQ-004 Parameter CW, default AW+1, width of busy_cnt.
REQ-005 clk  input  1  single clock; all state changes on its rising edge.
REQ-006 rst  input  1  asynchronous, active-high reset.
REQ-007 ren  input  NRP  per-port read enable; bit i belongs to port i.
REQ-008 raddr  input  NRP*AW  read addresses; port i occupies bits [i*AW +: AW].
REQ-009 rdata  output  NRP*DW  read data; port i occupies bits [i*DW +: DW].
REQ-010 we / waddr / wdata  input  1 / AW / DW  writeback-stage write.
REQ-011 ex_wen / ex_waddr / ex_wdata / ex_nofwd  input  1 / AW / DW / 1  EX bypass source; nofwd=1 means the data is not yet valid.
REQ-012 mem_wen / mem_waddr / mem_wdata / mem_nofwd  input  1 / AW / DW / 1  MEM bypass source, same meaning.
REQ-013 iss_valid / iss_addr  input  1 / AW  long-latency op issued; marks destination busy.
REQ-014 cmp_valid / cmp_addr  input  1 / AW  long-latency op completed; clears busy.
REQ-015 stallreq  output  1  decode must hold this cycle.
REQ-016 busy_cnt  output  CW  number of entries currently busy.

Function
REQ-017 Storage: 2**AW x DW array; entry 0 reads as 0 always; writes to entry 0 have no effect.
REQ-018 Write: on a rising edge with we=1 and waddr!=0, entry waddr takes wdata (1-cycle write latency).
REQ-019 Read is combinational; per port, priority: raddr==0 -> 0; EX hit (ex_wen, ex_waddr==raddr) -> ex_wdata; MEM hit -> mem_wdata; WB hit (we, waddr==raddr) -> wdata; else array.
REQ-020 Port valid: rv[i] = ren[i] && raddr[i]!=0; ports with rv=0 never cause a stall.
REQ-021 Forward stall: port i stalls if rv[i] and (EX hit and ex_nofwd) or (no EX hit, MEM hit and mem_nofwd).
REQ-022 Scoreboard: one busy bit per entry; bit 0 is constant 0.
REQ-023 On a rising edge: iss_valid with iss_addr!=0 sets busy[iss_addr]; cmp_valid clears busy[cmp_addr].
REQ-024 Same edge, iss_addr==cmp_addr: set wins (new issue overrides completion).
REQ-025 cmp_valid on a non-busy entry is ignored; iss_valid on an already-busy entry leaves it busy.
REQ-026 Scoreboard stall: port i stalls if rv[i], busy[raddr[i]]=1, and no EX/MEM/WB hit with nofwd=0 supplies raddr[i] that cycle.
REQ-027 stallreq = OR over all ports of forward stall and scoreboard stall; purely combinational from inputs and state.
REQ-028 busy_cnt is a register: +1 on a 0->1 busy transition, -1 on a 1->0 transition, net change per edge in {-1,0,+1}; never wraps.
REQ-029 stallreq does not gate iss_valid, cmp_valid or we; the pipeline controls those.

Reset
REQ-030 While rst=1: all array entries = 0, all busy bits = 0, busy_cnt = 0, regardless of clk.
REQ-031 rst asserted mid-operation discards pending busy state; a later cmp_valid to a cleared entry is ignored.
REQ-032 Outputs during reset: rdata reflects bypass inputs or 0; stallreq follows REQ-027 with empty scoreboard.

Verification
REQ-033 Write 0xDEADBEEF to entry 5, read port 0 addr 5 next cycle -> rdata0=0xDEADBEEF; write to entry 0 -> rdata=0.
REQ-034 ex_wen=1, ex_waddr=3, ex_wdata=0x11, mem hit on 3 with 0x22, ren0=1 raddr0=3 -> rdata0=0x11, stallreq=0; set ex_nofwd=1 -> stallreq=1.
REQ-035 iss_valid on entry 7, read 7 next cycle -> stallreq=1, busy_cnt=1; cmp_valid+we on 7 with 0x55 -> same cycle rdata=0x55, stallreq=0; next cycle busy_cnt=0.
REQ-036 iss_valid and cmp_valid both to entry 9 same edge -> busy[9]=1, busy_cnt unchanged at 1 if already busy, 1 if newly set.
REQ-037 Issue entries 1..31 back to back -> busy_cnt=31; assert rst asynchronously -> busy_cnt=0, stallreq=0, all reads 0.
REQ-038 NRP=4 build: only port 3 reads a busy entry with ren3=1 -> stallreq=1; ren3=0 -> stallreq=0.
